seq_comp: RTL and testbench
===========================

SEQ_COMP -- requirements
Module: seq_comp

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (>=2).
REQ-002 SHALL have parameter CHUNK, default 4, bits compared per cycle (WIDTH % CHUNK == 0).
REQ-003 SHALL have clk  input  1  sole clock; every register updates on the rising edge.
REQ-004 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have a  input  WIDTH  operand A.
REQ-006 SHALL have b  input  WIDTH  operand B.
REQ-007 SHALL have sgn  input  1  1 = two's-complement compare, 0 = unsigned compare.
REQ-008 SHALL have in_valid  input  1  operands present.
REQ-009 SHALL have in_ready  output  1  block can accept operands.
REQ-010 SHALL have eq  output  1  A == B.
REQ-011 SHALL have gt  output  1  A > B.
REQ-012 SHALL have lt  output  1  A < B.
REQ-013 SHALL have cycles  output  clog2(WIDTH/CHUNK)+1  number of SCAN cycles used.
REQ-014 SHALL have out_valid  output  1  result present.
REQ-015 SHALL have out_ready  input  1  consumer accepts result.

Function
REQ-016 SHALL implement FSM states IDLE, SCAN, DONE; in_ready = (state == IDLE) and does not depend on out_ready.
REQ-017 SHALL capture a, b and sgn on a clock edge where state is IDLE and in_valid is 1, then move to SCAN with the chunk index at NCHUNK-1 (NCHUNK = WIDTH/CHUNK).
REQ-018 SHALL, when sgn is captured as 1, invert the MSB of both captured operands, then compare them as unsigned.
REQ-019 SHALL, in each SCAN cycle, compare chunk [idx*CHUNK +: CHUNK] of A and B, MSB chunk first.
REQ-020 SHALL, when the current chunks differ, register gt or lt from that chunk and move to DONE (early exit).
REQ-021 SHALL, when the current chunks are equal and idx == 0, register eq = 1 and move to DONE; otherwise it SHALL decrement idx and stay in SCAN.
REQ-022 SHALL register cycles = number of SCAN cycles spent (range 1..NCHUNK); out_valid is asserted 1..NCHUNK cycles after the capture edge.
REQ-023 SHALL assert out_valid only in DONE; exactly one of eq/gt/lt SHALL be 1 while out_valid is 1.
REQ-024 SHALL force eq, gt, lt and cycles to 0 while out_valid is 0.
REQ-025 SHALL hold eq, gt, lt and cycles stable in DONE until out_ready is 1, then move to IDLE.
REQ-026 SHALL have no same-cycle bypass: a new capture occurs no earlier than the cycle after DONE exits.
REQ-027 SHALL ignore in_valid while in SCAN or DONE; operands presented then are not captured.
REQ-028 SHALL, with WIDTH == CHUNK, complete in exactly 1 SCAN cycle.

Reset
REQ-029 SHALL, when rst = 1 at a clock edge, go to IDLE with in_ready = 1, out_valid = 0, eq/gt/lt/cycles = 0, and idx = 0.
REQ-030 SHALL, when reset is asserted in SCAN or DONE, abort the operation, discard the pending result, and give rst priority over in_valid and out_ready.

Structure
REQ-031 SHALL place the state enum, NCHUNK and CNT_W localparams, and result encoding in package seq_comp_pkg.
REQ-032 SHALL instantiate one combinational sub-module, chunk_cmp (CHUNK-bit unsigned compare producing eq/gt/lt), per SCAN step.

Verification (WIDTH=16, CHUNK=4)
REQ-033 SHALL cover unsigned a=0x1234, b=0x1234 -> eq=1, cycles=4, out_valid 4 cycles after capture.
REQ-034 SHALL cover a=0x8000, b=0x7FFF -> sgn=0: gt=1, cycles=1; sgn=1: lt=1, cycles=1.
REQ-035 SHALL cover unsigned a=0x12F4, b=0x1304 -> lt=1, cycles=2.
REQ-036 SHALL cover out_ready held 0 for 5 cycles in DONE while in_valid=1 with new operands -> outputs stable, in_ready=0, no capture; the result is released on out_ready=1.
REQ-037 SHALL cover rst=1 during the second SCAN cycle -> next cycle in_ready=1, out_valid=0, all results 0; a following compare of 0xFFFF vs 0x0000 (sgn=1) gives lt=1.
REQ-038 SHALL cover back-to-back compares with out_ready and in_valid tied to 1 -> each result is accepted, with one IDLE cycle between DONE and the next capture.

Source files
------------

// File: rtl/seq_comp_pkg.sv
// Shared types and sizing helpers for the chunk-serial magnitude comparator.
// Sizing helpers let the top derive its widths from its own WIDTH/CHUNK parameters.
package seq_comp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam int WIDTH_DEF = 16;
  localparam int CHUNK_DEF = 4;
  localparam int NCHUNK    = WIDTH_DEF / CHUNK_DEF;
  localparam int CNT_W     = $clog2(NCHUNK) + 1;

  // Registered result; exactly one field is set once a compare has finished.
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } cmp_res_t;

  localparam cmp_res_t RES_NONE = '0;

  function automatic int nchunk_of(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic int cnt_w_of(input int width, input int chunk);
    return $clog2(width / chunk) + 1;
  endfunction

  function automatic int idx_w_of(input int width, input int chunk);
    return (width / chunk > 1) ? $clog2(width / chunk) : 1;
  endfunction

endpackage

// File: rtl/seq_comp_chunk_cmp.sv
// Combinational unsigned compare of one CHUNK-wide slice of each operand.
module chunk_cmp #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         eq,
  output logic         gt,
  output logic         lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/seq_comp.sv
// Multi-cycle magnitude comparator: scans operands one chunk per cycle from the
// MSB end and stops at the first differing chunk.
module seq_comp
  import seq_comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic                           sgn,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           eq,
  output logic                           gt,
  output logic                           lt,
  output logic [$clog2(WIDTH/CHUNK):0]   cycles,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int NUM_CHUNKS = nchunk_of(WIDTH, CHUNK);
  localparam int CYC_W      = cnt_w_of(WIDTH, CHUNK);
  localparam int IDX_W      = idx_w_of(WIDTH, CHUNK);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IDX_W-1:0] idx;
  logic [CYC_W-1:0] cnt;
  cmp_res_t         res;

  logic [CHUNK-1:0] a_chunks [NUM_CHUNKS];
  logic [CHUNK-1:0] b_chunks [NUM_CHUNKS];
  logic [CHUNK-1:0] a_cur, b_cur;
  logic             c_eq, c_gt, c_lt;

  for (genvar g = 0; g < NUM_CHUNKS; g++) begin : g_split
    assign a_chunks[g] = a_q[g*CHUNK +: CHUNK];
    assign b_chunks[g] = b_q[g*CHUNK +: CHUNK];
  end

  always_comb begin
    a_cur = '0;
    b_cur = '0;
    for (int i = 0; i < NUM_CHUNKS; i++) begin
      if (idx == IDX_W'(i)) begin
        a_cur = a_chunks[i];
        b_cur = b_chunks[i];
      end
    end
  end

  chunk_cmp #(.W(CHUNK)) u_chunk_cmp (
    .a  (a_cur),
    .b  (b_cur),
    .eq (c_eq),
    .gt (c_gt),
    .lt (c_lt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = SCAN;
      SCAN:    if (!c_eq || idx == '0) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flipping the sign bit maps two's-complement order onto unsigned order,
  // so the scan itself never needs to know about signedness.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      idx <= '0;
      cnt <= '0;
      res <= RES_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a ^ {sgn, {(WIDTH-1){1'b0}}};
            b_q <= b ^ {sgn, {(WIDTH-1){1'b0}}};
            idx <= IDX_W'(NUM_CHUNKS - 1);
            cnt <= '0;
            res <= RES_NONE;
          end
        end
        SCAN: begin
          cnt <= cnt + CYC_W'(1);
          if (!c_eq)            res <= '{eq: 1'b0, gt: c_gt, lt: c_lt};
          else if (idx == '0)   res <= '{eq: 1'b1, gt: 1'b0, lt: 1'b0};
          else                  idx <= idx - IDX_W'(1);
        end
        DONE: begin
          if (out_ready) begin
            res <= RES_NONE;
            cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    eq        = 1'b0;
    gt        = 1'b0;
    lt        = 1'b0;
    cycles    = '0;
    if (state == DONE) begin
      eq     = res.eq;
      gt     = res.gt;
      lt     = res.lt;
      cycles = cnt;
    end
  end

endmodule

// File: tb/tb_seq_comp.sv
// Directed bench for seq_comp (WIDTH=16, CHUNK=4) with a queue-based scoreboard
// fed by a behavioural compare model.
module tb_seq_comp;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        sgn;
  logic        in_valid;
  logic        in_ready;
  logic        eq, gt, lt;
  logic [2:0]  cycles;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic       eq;
    logic       gt;
    logic       lt;
    logic [2:0] cycles;
  } exp_t;

  exp_t sb[$];
  int   cap_q[$];
  int   cycle_cnt = 0;
  int   tests = 0;
  int   fails = 0;

  seq_comp #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .sgn       (sgn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt),
    .cycles    (cycles),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: relational result from native signed/unsigned compare; cycle
  // count is the position of the first differing nibble in sign-biased order.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
    exp_t        e;
    logic [15:0] bx, by;
    if (s) begin
      e.gt = $signed(x) > $signed(y);
      e.lt = $signed(x) < $signed(y);
    end else begin
      e.gt = x > y;
      e.lt = x < y;
    end
    e.eq = (x == y);
    bx = s ? {~x[15], x[14:0]} : x;
    by = s ? {~y[15], y[14:0]} : y;
    e.cycles = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if (bx[i*4 +: 4] != by[i*4 +: 4]) begin
        e.cycles = 3'(4 - i);
        break;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic s);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk("in_ready_before_capture", int'(in_ready), 1);
    a = x;
    b = y;
    sgn = s;
    in_valid = 1'b1;
    sb.push_back(model(x, y, s));
    tick();
    cap_q.push_back(cycle_cnt);
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic release_it);
    exp_t e;
    int   waited = 0;
    int   lat;
    while (out_valid !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    chk({tag, "_out_valid"}, int'(out_valid), 1);
    if (out_valid === 1'b1 && sb.size() > 0 && cap_q.size() > 0) begin
      e   = sb.pop_front();
      lat = cycle_cnt - cap_q.pop_front();
      chk({tag, "_eq"}, int'(eq), int'(e.eq));
      chk({tag, "_gt"}, int'(gt), int'(e.gt));
      chk({tag, "_lt"}, int'(lt), int'(e.lt));
      chk({tag, "_cycles"}, int'(cycles), int'(e.cycles));
      chk({tag, "_latency"}, lat, int'(e.cycles));
    end
    if (release_it) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, "_released"}, int'(out_valid), 0);
      chk({tag, "_cleared"}, int'({eq, gt, lt, cycles}), 0);
    end
  endtask

  initial begin
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic        vs [4];
    exp_t        e;
    int          k;
    logic        after_done;

    rst = 1'b1; a = '0; b = '0; sgn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_results", int'({eq, gt, lt, cycles}), 0);
    tick();
    rst = 1'b0;

    applyStimulus(16'h1234, 16'h1234, 1'b0);
    checkOutput("eq_full_scan", 1'b1);
    applyStimulus(16'h8000, 16'h7FFF, 1'b0);
    checkOutput("unsigned_msb", 1'b1);
    applyStimulus(16'h8000, 16'h7FFF, 1'b1);
    checkOutput("signed_msb", 1'b1);
    applyStimulus(16'h12F4, 16'h1304, 1'b0);
    checkOutput("lt_second_chunk", 1'b1);
    applyStimulus(16'h0F0F, 16'h0F0E, 1'b1);
    checkOutput("gt_last_chunk", 1'b1);

    // Hold DONE with out_ready low while new operands are offered.
    applyStimulus(16'hA000, 16'h5000, 1'b0);
    checkOutput("hold_first", 1'b0);
    a = 16'h0001; b = 16'h0002; sgn = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_in_ready", int'(in_ready), 0);
      chk("hold_result", int'({eq, gt, lt, cycles}), int'({1'b0, 1'b1, 1'b0, 3'd1}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hold_release_out_valid", int'(out_valid), 0);
    chk("hold_release_in_ready", int'(in_ready), 1);
    tick();
    chk("hold_no_capture", int'(in_ready), 1);

    // Reset during the second scan cycle discards the pending compare.
    applyStimulus(16'h1234, 16'h1234, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    cap_q.delete();
    chk("midscan_reset_in_ready", int'(in_ready), 1);
    chk("midscan_reset_out_valid", int'(out_valid), 0);
    chk("midscan_reset_results", int'({eq, gt, lt, cycles}), 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midscan_reset_discarded", int'(out_valid), 0);
    end
    applyStimulus(16'hFFFF, 16'h0000, 1'b1);
    checkOutput("after_reset_signed", 1'b1);

    // Back-to-back with both handshakes tied high.
    va[0] = 16'h4321; vb[0] = 16'h4321; vs[0] = 1'b0;
    va[1] = 16'h0010; vb[1] = 16'h0020; vs[1] = 1'b0;
    va[2] = 16'hFFF0; vb[2] = 16'h0005; vs[2] = 1'b1;
    va[3] = 16'h7A00; vb[3] = 16'h7B00; vs[3] = 1'b1;
    k = 0;
    after_done = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (out_valid === 1'b1) begin
        if (sb.size() > 0 && cap_q.size() > 0) begin
          e = sb.pop_front();
          chk("b2b_cycles", int'(cycles), int'(e.cycles));
          chk("b2b_latency", cycle_cnt - cap_q.pop_front(), int'(e.cycles));
          chk("b2b_result", int'({eq, gt, lt}), int'({e.eq, e.gt, e.lt}));
        end
        after_done = 1'b1;
      end else if (after_done) begin
        chk("b2b_idle_gap", int'(in_ready), 1);
        after_done = 1'b0;
      end
      if (in_ready === 1'b1 && k < 4) begin
        a = va[k]; b = vb[k]; sgn = vs[k];
        sb.push_back(model(va[k], vb[k], vs[k]));
        cap_q.push_back(cycle_cnt + 1);
        k++;
      end else if (k >= 4) begin
        in_valid = 1'b0;
      end
      if (k >= 4 && sb.size() == 0) break;
      tick();
    end
    chk("b2b_all_accepted", sb.size(), 0);
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
